adc4_base_trig: RTL and testbench

Per-channel baseline restorer and self-trigger for one 4-channel ADC receiver. It sits directly downstream of the 4-channel deserializer and consumes its 48-bit CLK-domain sample word. For each channel it tracks a pedestal by block averaging and outputs baseline-subtracted signed samples. It also raises a one-cycle trigger when a sample exceeds a programmable threshold, then holds off for a fixed period.

---
 rtl/adc4_base_trig.sv | 117 +++++++++++
 tb/tb_adc4_base_trig.sv | 136 +++++++++++++
 2 files changed

// File: rtl/adc4_base_trig.sv
// Four-channel baseline restorer with per-channel self-trigger and holdoff.
// Each channel block-averages its pedestal and outputs signed, baseline-subtracted samples.
module adc4_base_trig_ch #(
  parameter int unsigned NAVG_LOG2 = 4,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] din,
  input  logic        enable,
  input  logic [11:0] thr,
  output logic [12:0] dout,
  output logic        trig,
  output logic        bvalid
);
  localparam int unsigned AW = 12 + NAVG_LOG2;
  localparam logic [NAVG_LOG2-1:0] N_ONE = NAVG_LOG2'(1);

  logic [11:0]          s;
  logic                 s_vld;
  logic [11:0]          b;
  logic [AW-1:0]        acc;
  logic [NAVG_LOG2-1:0] n;
  logic [7:0]           h;

  logic signed [12:0]   d;
  logic [AW-1:0]        acc_sum;
  logic                 fire;
  logic                 wrap;

  always_comb begin
    d       = $signed({1'b0, s}) - $signed({1'b0, b});
    acc_sum = acc + AW'(s);
    wrap    = &n;
    fire    = enable & bvalid & (h == 8'd0) & (d > $signed({1'b0, thr}));
  end

  // s_vld keeps the zero left in S by reset out of the first block after RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s      <= '0;
      s_vld  <= 1'b0;
      b      <= '0;
      acc    <= '0;
      n      <= '0;
      h      <= '0;
      dout   <= '0;
      trig   <= 1'b0;
      bvalid <= 1'b0;
    end else begin
      s     <= din;
      s_vld <= 1'b1;
      dout  <= d;
      trig  <= fire;
      if (fire) begin
        // trigger wins over a coinciding block completion; the block is dropped
        h   <= 8'(HOLDOFF);
        acc <= '0;
        n   <= '0;
      end else if (h != 8'd0) begin
        h   <= h - 8'd1;
        acc <= '0;
        n   <= '0;
      end else if (s_vld) begin
        if (wrap) begin
          b      <= acc_sum[AW-1:NAVG_LOG2];
          acc    <= '0;
          n      <= '0;
          bvalid <= 1'b1;
        end else begin
          acc <= acc_sum;
          n   <= n + N_ONE;
        end
      end
    end
  end
endmodule

module adc4_base_trig #(
  parameter int unsigned NAVG_LOG2 = 4,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [47:0] DIN,
  input  logic        ENABLE,
  input  logic [11:0] THR,
  output logic [51:0] DOUT,
  output logic [3:0]  TRIG,
  output logic        TRIGANY,
  output logic [3:0]  BVALID
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][11:0] din_l;
  logic [NUM_LANES-1:0][12:0] dout_l;

  assign din_l   = DIN;
  assign DOUT    = dout_l;
  assign TRIGANY = |TRIG;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_ch
    adc4_base_trig_ch #(
      .NAVG_LOG2 (NAVG_LOG2),
      .HOLDOFF   (HOLDOFF)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .din    (din_l[k]),
      .enable (ENABLE),
      .thr    (THR),
      .dout   (dout_l[k]),
      .trig   (TRIG[k]),
      .bvalid (BVALID[k])
    );
  end
endmodule

// File: tb/tb_adc4_base_trig.sv
// Directed-vector bench: stimulus pushes hand-computed expectations tagged with the
// edge they are due on; a negedge monitor pops and compares them.
module tb_adc4_base_trig;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [47:0] DIN = '0;
  logic        ENABLE = 1'b1;
  logic [11:0] THR = 12'd100;
  logic [51:0] DOUT;
  logic [3:0]  TRIG;
  logic        TRIGANY;
  logic [3:0]  BVALID;

  adc4_base_trig dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .ENABLE(ENABLE), .THR(THR),
    .DOUT(DOUT), .TRIG(TRIG), .TRIGANY(TRIGANY), .BVALID(BVALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          tag;
    logic [51:0] dout;
    logic [3:0]  trig;
    logic        tany;
    logic [3:0]  bv;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (q.size() != 0 && q[0].tag < cyc) begin
      n_chk++;
      $display("FAIL missed_output tag=%0d now=%0d", q[0].tag, cyc);
      void'(q.pop_front());
    end
    if (q.size() != 0 && q[0].tag == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (DOUT === e.dout && TRIG === e.trig && TRIGANY === e.tany && BVALID === e.bv)
        n_pass++;
      else
        $display("FAIL out@%0d got dout=%h trig=%b any=%b bv=%b want dout=%h trig=%b any=%b bv=%b",
                 cyc, DOUT, TRIG, TRIGANY, BVALID, e.dout, e.trig, e.tany, e.bv);
    end
  end

  // Drive one vector; its outputs are due two edges later (reset: one edge later).
  task automatic vec(input logic rst, input int d0, input int d1, input int d2, input int d3,
                     input int e0, input int e1, input int e2, input int e3,
                     input logic [3:0] et, input logic [3:0] ebv, input bit chk);
    exp_t e;
    RST = rst;
    DIN = {12'(d3), 12'(d2), 12'(d1), 12'(d0)};
    if (chk) begin
      e.tag  = rst ? cyc + 1 : cyc + 2;
      e.dout = {13'(e3), 13'(e2), 13'(e1), 13'(e0)};
      e.trig = et;
      e.tany = |et;
      e.bv   = ebv;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input int n, input int d, input int e, input logic [3:0] ebv);
    for (int i = 0; i < n; i++) vec(1'b0, d, d, d, d, e, e, e, e, 4'h0, ebv, 1'b1);
  endtask

  initial begin
    vec(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1'b1);
    vec(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1'b1);
    // first block: B=0 so DOUT=+1000; BVALID with the 16th sample
    fill(15, 1000, 1000, 4'h0);
    fill(1, 1000, 1000, 4'hF);
    fill(16, 1000, 0, 4'hF);                                              // i 16..31
    vec(1'b0, 1101, 1000, 1000, 1000, 101, 0, 0, 0, 4'b0001, 4'hF, 1'b1); // i 32 trigger
    fill(7, 1000, 0, 4'hF);
    vec(1'b0, 1000, 1100, 1000, 1000, 0, 100, 0, 0, 4'h0, 4'hF, 1'b1);   // i 40 D==THR
    vec(1'b0, 1000, 900, 1000, 1000, 0, -100, 0, 0, 4'h0, 4'hF, 1'b1);
    vec(1'b0, 1101, 1000, 1000, 1000, 101, 0, 0, 0, 4'h0, 4'hF, 1'b1);   // i 42 holdoff
    fill(7, 1000, 0, 4'hF);
    ENABLE = 1'b0;
    vec(1'b0, 1000, 1000, 1101, 1000, 0, 0, 101, 0, 4'h0, 4'hF, 1'b1);   // i 50 disabled
    vec(1'b0, 1000, 1000, 899, 1000, 0, 0, -101, 0, 4'h0, 4'hF, 1'b1);
    ENABLE = 1'b1;
    fill(11, 1000, 0, 4'hF);
    vec(1'b0, 1000, 1000, 1000, 1101, 0, 0, 0, 101, 4'b1000, 4'hF, 1'b1); // i 63 = 16th of block
    fill(32, 1000, 0, 4'hF);
    vec(1'b0, 1101, 1000, 1000, 1000, 101, 0, 0, 0, 4'h0, 4'hF, 1'b1);   // i 96 last holdoff cycle
    vec(1'b0, 1101, 1000, 1000, 1000, 101, 0, 0, 0, 4'b0001, 4'hF, 1'b1); // i 97 = 65 after
    fill(2, 1000, 0, 4'hF);
    vec(1'b0, 1000, 1000, 1000, 2000, 0, 0, 0, 1000, 4'h0, 4'hF, 1'b1);  // i 100 frozen accum
    fill(27, 1000, 0, 4'hF);
    // ch3 fresh block starts at i 128 exactly
    for (int i = 0; i < 16; i++) vec(1'b0, 1000, 1000, 1000, 1016, 0, 0, 0, 16, 4'h0, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++)  vec(1'b0, 1000, 1000, 1000, 1016, 0, 0, 0, 0, 4'h0, 4'hF, 1'b1);
    vec(1'b0, 1500, 1500, 1500, 1500, 0, 0, 0, 0, 4'h0, 4'hF, 1'b0);
    // mid-operation reset
    vec(1'b1, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 4'h0, 4'h0, 1'b1);
    fill(15, 1000, 1000, 4'h0);
    fill(1, 1000, 1000, 4'hF);
    fill(4, 1000, 0, 4'hF);
    vec(1'b0, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0);
    // baseline 4095 then DIN=0
    vec(1'b1, 4095, 4095, 4095, 4095, 0, 0, 0, 0, 4'h0, 4'h0, 1'b1);
    fill(15, 4095, 4095, 4'h0);
    fill(1, 4095, 4095, 4'hF);
    fill(3, 0, -4095, 4'hF);
    vec(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0);
    // baseline 0 then DIN=4095 with THR=4094
    THR = 12'd4094;
    vec(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1'b1);
    fill(15, 0, 0, 4'h0);
    fill(1, 0, 0, 4'hF);
    vec(1'b0, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4'hF, 4'hF, 1'b1);
    vec(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1'b1);
    vec(1'b0, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4'h0, 4'hF, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    while (q.size() != 0) begin
      n_chk++;
      $display("FAIL never_checked tag=%0d", q[0].tag);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
